// File: rtl/ftrace_buf.sv
// Function-trace buffer: captures call/return events from commit into a circular FIFO
// and tracks live call depth, dropped-event count and a sticky overflow flag.
module ftrace_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_valid,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_dnpc,
    input  logic          ev_call,
    input  logic          ev_ret,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_kind,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_target,
    output logic [7:0]    rd_depth,
    output logic [7:0]    cur_depth,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    input  logic          clr_ovf
);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] target;
        logic [7:0]  depth;
    } entry_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic [AW:0]   count_q;
    logic [7:0]    depth_q;
    logic [7:0]    depth_nxt;
    logic [7:0]    rec_depth;
    logic          overflow_q;
    logic [15:0]   drop_cnt_q;
    logic          ev;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    // Read port handshake: rd_valid means the head entry is on rd_*; an entry is
    // consumed on a rising edge where rd_valid & rd_ready, and rd_* never change
    // while rd_valid is high and rd_ready is low.
    always_comb begin
        ev    = commit_valid & (ev_call | ev_ret);
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        pop   = ~empty & rd_ready;
        push  = ev & (~full | pop);
        drop  = ev & full & ~pop;
    end

    // Calls record the depth they were made from; returns record the depth they
    // land on, so matched pairs carry the same value.
    always_comb begin
        depth_nxt = depth_q;
        rec_depth = depth_q;
        if (ev) begin
            if (ev_call) begin
                if (depth_q != 8'hFF) depth_nxt = depth_q + 8'd1;
            end else begin
                if (depth_q != 8'h00) depth_nxt = depth_q - 8'd1;
                rec_depth = depth_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp         <= '0;
            wp         <= '0;
            count_q    <= '0;
            depth_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            depth_q <= depth_nxt;
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear still leaves evidence of itself.
            if (drop) begin
                overflow_q <= 1'b1;
                if (clr_ovf)                    drop_cnt_q <= 16'd1;
                else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= '{kind: ~ev_call, pc: commit_pc, target: commit_dnpc, depth: rec_depth};
    end

    assign head      = mem[rp];
    assign rd_valid  = ~empty;
    assign rd_kind   = head.kind;
    assign rd_pc     = head.pc;
    assign rd_target = head.target;
    assign rd_depth  = head.depth;
    assign cur_depth = depth_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ftrace_buf.sv
// Bench for ftrace_buf: queue-based reference model fed by stimulus, negedge
// monitor comparing the DUT against it, directed cases followed by random traffic.
module tb_ftrace_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_dnpc;
    logic        ev_call;
    logic        ev_ret;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_kind;
    logic [31:0] rd_pc;
    logic [31:0] rd_target;
    logic [7:0]  rd_depth;
    logic [7:0]  cur_depth;
    logic [AW:0] count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    ftrace_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_dnpc(commit_dnpc),
        .ev_call(ev_call), .ev_ret(ev_ret),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_kind(rd_kind),
        .rd_pc(rd_pc), .rd_target(rd_target), .rd_depth(rd_depth),
        .cur_depth(cur_depth), .count(count), .overflow(overflow),
        .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    int          checks = 0;
    int          errors = 0;
    logic [72:0] exp_q[$];
    int          m_depth = 0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drops = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds exactly what the reader should see; its size is the count.
    always @(posedge clk or posedge rst) begin
        logic       kind;
        logic [7:0] rec;
        logic       dropped;
        if (rst) begin
            exp_q.delete();
            m_depth = 0;
            m_ovf   = 1'b0;
            m_drops = '0;
        end else begin
            dropped = 1'b0;
            if (commit_valid && (ev_call || ev_ret)) begin
                if (ev_call) begin
                    kind = 1'b0;
                    rec  = 8'(m_depth);
                    m_depth = (m_depth < 255) ? m_depth + 1 : 255;
                end else begin
                    kind = 1'b1;
                    m_depth = (m_depth > 0) ? m_depth - 1 : 0;
                    rec  = 8'(m_depth);
                end
                // Any same-cycle pop was already taken off the queue by the monitor.
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back({kind, commit_pc, commit_dnpc, rec});
                end else begin
                    dropped = 1'b1;
                    m_ovf   = 1'b1;
                    if (clr_ovf) m_drops = 16'd1;
                    else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
            end
            if (!dropped && clr_ovf) begin
                m_ovf   = 1'b0;
                m_drops = '0;
            end
        end
    end

    // Monitor: compare outputs mid-cycle; retire the head when the reader takes it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_valid", rd_valid, exp_q.size() > 0);
            chk("count", count, exp_q.size());
            chk("cur_depth", cur_depth, m_depth);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drops);
            if (exp_q.size() > 0) begin
                chk("head_entry", {rd_kind, rd_pc, rd_target, rd_depth}, exp_q[0]);
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_pc(input logic v, input logic c, input logic r, input logic rdy,
                           input logic clr, input logic [31:0] pc, input logic [31:0] dnpc);
        commit_valid = v;
        ev_call      = c;
        ev_ret       = r;
        rd_ready     = rdy;
        clr_ovf      = clr;
        commit_pc    = pc;
        commit_dnpc  = dnpc;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic c, input logic r, input logic rdy, input logic clr);
        step_pc(v, c, r, rdy, clr, $urandom(), $urandom());
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_done", exp_q.size(), 0);
        chk("drain_rd_valid", rd_valid, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        commit_valid = 0; commit_pc = 0; commit_dnpc = 0;
        ev_call = 0; ev_ret = 0; rd_ready = 0; clr_ovf = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_count", count, 0);
        chk("reset_cur_depth", cur_depth, 0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Call then return, reader stalled.
        step_pc(1, 1, 0, 0, 0, 32'h8000_0000, 32'h8000_0100);
        step_pc(1, 0, 1, 0, 0, 32'h8000_0104, 32'h8000_0004);
        step(0, 0, 0, 0, 0);
        chk("pair_count", count, 2);
        chk("pair_cur_depth", cur_depth, 0);
        chk("pair_first", {rd_valid, rd_kind, rd_pc, rd_target, rd_depth},
            {1'b1, 1'b0, 32'h8000_0000, 32'h8000_0100, 8'd0});
        step(0, 0, 0, 1, 0);
        chk("pair_second", {rd_valid, rd_kind, rd_pc, rd_target, rd_depth},
            {1'b1, 1'b1, 32'h8000_0104, 32'h8000_0004, 8'd0});
        drain();

        // Nested calls, then an unmatched return at depth 0.
        repeat (3) step(1, 1, 0, 0, 0);
        chk("nest_peak", cur_depth, 3);
        repeat (3) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("nest_floor", cur_depth, 0);
        chk("nest_count", count, 7);
        drain();

        // Fill, overflow by three, then a drop coinciding with a clear.
        repeat (16) step(1, 1, 0, 0, 0);
        repeat (3) step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", drop_cnt, 3);
        step(1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("ovf_drop_beats_clr", {overflow, drop_cnt}, {1'b1, 16'd1});
        drain();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("clr_flag", overflow, 1'b0);
        chk("clr_drops", drop_cnt, 0);

        // Full FIFO streaming with simultaneous pop and push across wrap.
        repeat (16) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 1'($urandom_range(0, 1)), 1'b1, 1, 0);
            chk("stream_count", count, 16);
            chk("stream_ovf", overflow, 1'b0);
        end
        drain();

        // Qualification and call-priority.
        d0 = m_depth;
        step(0, 1, 0, 0, 0);
        chk("unqual_count", count, 0);
        chk("unqual_depth", cur_depth, d0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("both_kind", {rd_valid, rd_kind}, {1'b1, 1'b0});
        chk("both_depth", cur_depth, d0 + 1);
        drain();

        // Asynchronous reset with five entries held.
        repeat (5) step(1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_valid", rd_valid, 1'b0);
        chk("arst_count", count, 0);
        chk("arst_cur_depth", cur_depth, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step_pc(1, 1, 0, 0, 0, 32'h8000_2000, 32'h8000_3000);
        step(0, 0, 0, 0, 0);
        chk("arst_first", {rd_valid, count, rd_kind, rd_pc, rd_target, rd_depth},
            {1'b1, 5'd1, 1'b0, 32'h8000_2000, 32'h8000_3000, 8'd0});
        drain();

        // Depth saturation at 255.
        repeat (258) step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("sat_depth", cur_depth, 255);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("sat_ret_depth", cur_depth, 254);
        drain();

        // Random traffic with bursts of stalled reader to provoke drops.
        for (int i = 0; i < 600; i++) begin
            logic stall;
            stall = ((i / 50) % 2) == 1;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 stall ? 1'($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ftrace_buf.md
# ftrace_buf

Hardware function-trace buffer sitting directly downstream of the commit-stage call/return classifier in the NPC core. Each retired instruction classified as a call or a return is captured together with its PC, jump target and current call depth. The record goes into a circular FIFO, which a debug reader drains through a valid/ready port. The block also tracks call depth, counts dropped events and raises a sticky overflow flag when events are lost.

## Interface
Parameters:
- `DEPTH`, 16, number of FIFO entries; power of two, minimum 2
- `AW`, 4, pointer width; must equal log2(DEPTH)

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `commit_valid`  in  1  an instruction retires this cycle
- `commit_pc`  in  32  PC of the retiring instruction
- `commit_dnpc`  in  32  next PC (jump target) of the retiring instruction
- `ev_call`  in  1  retiring instruction is a call (jal/jalr with rd=x1)
- `ev_ret`  in  1  retiring instruction is a return (jalr x0,0(x1))
- `rd_valid`  out  1  head entry available
- `rd_ready`  in  1  reader accepts head entry
- `rd_kind`  out  1  head entry kind: 0 = call, 1 = return
- `rd_pc`  out  32  head entry PC
- `rd_target`  out  32  head entry target
- `rd_depth`  out  8  head entry depth
- `cur_depth`  out  8  live call depth
- `count`  out  AW+1  entries currently stored
- `overflow`  out  1  sticky: at least one event dropped
- `drop_cnt`  out  16  dropped events, saturating at 16'hFFFF
- `clr_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`

## Operation
- Event qualification:
  - `ev = commit_valid & (ev_call | ev_ret)`.
  - If `ev_call` and `ev_ret` are both high, the instruction is treated as a call only.
- Depth tracking, on every qualified event, including dropped ones:
  - A call increments `cur_depth`, saturating at 255.
  - A return decrements `cur_depth`, saturating at 0.
- Recorded depth:
  - A call records `cur_depth` before the increment.
  - A return records `cur_depth` after the decrement.
  - A matched call/return pair therefore carries equal `rd_depth`.
- FIFO:
  - `DEPTH`-entry storage with head pointer `rp` and tail pointer `wp`, each AW bits and wrapping modulo `DEPTH`.
  - Separate `count` register, 0..DEPTH.
  - `full = (count == DEPTH)`; `empty = (count == 0)`.
- Read side:
  - Show-ahead: `rd_*` reflect the entry at `rp` combinationally.
  - `rd_valid = ~empty`.
  - Pop occurs when `rd_valid & rd_ready`.
- Write side:
  - Push is accepted when `ev & (~full | pop)`.
  - When full with no simultaneous pop, the event is dropped: the newest event is discarded and stored entries are kept.
  - A drop sets `overflow` and increments `drop_cnt`, saturating.
- `count` update:
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - Push only: +1.
  - Pop only: −1.
- `clr_ovf`:
  - Clears `overflow` to 0 and `drop_cnt` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- Storage array is not reset. Only control state is reset.

## Timing
- Reset, asynchronous: `rp`, `wp`, `count`, `cur_depth`, `overflow` and `drop_cnt` all go to 0.
  - Outputs during reset: `rd_valid` = 0, `count` = 0, `cur_depth` = 0, `overflow` = 0, `drop_cnt` = 0.
  - `rd_kind`/`rd_pc`/`rd_target`/`rd_depth` are don't-care while `rd_valid` = 0.
- Reset mid-operation: all buffered entries are discarded and depth returns to 0. No partial pop is reported.
- Latency:
  - An event sampled at edge N appears on `rd_*` with `rd_valid` = 1 after edge N (one cycle) when the FIFO was empty.
  - `cur_depth` reflects the event after edge N.
- Back-to-back events every cycle are supported at full throughput while not full.
- Pop takes effect at the edge. The next entry, or `rd_valid` = 0, is visible after that edge.
- Pointer wrap: the pointer after index `DEPTH`−1 is 0, with no bubble.

## Test plan
- Reset, then commit call pc=0x80000000 dnpc=0x80000100, then return pc=0x80000104 dnpc=0x80000004 with `rd_ready` = 0:
  - Required: `count` = 2, `cur_depth` = 0.
  - Entries read out in order: (0, 0x80000000, 0x80000100, 0) then (1, 0x80000104, 0x80000004, 0).
- Nested calls: 3 calls then 3 returns:
  - Required recorded depths: 0,1,2,2,1,0.
  - `cur_depth` peaks at 3.
  - A return at depth 0 records 0 and stays at 0.
- Fill 16 events with `rd_ready` = 0, then 3 more:
  - Required: `count` = 16, `overflow` = 1, `drop_cnt` = 3.
  - Drain yields the first 16 in order.
  - `clr_ovf` then gives `overflow` = 0, `drop_cnt` = 0.
- Full FIFO with simultaneous pop and push:
  - Required: `count` stays 16 and `overflow` stays 0.
  - Stream 40 events with `rd_ready` = 1 held; all 40 are read in order across pointer wrap.
- `commit_valid` = 0 with `ev_call` = 1:
  - Required: no push, no depth change.
  - `ev_call` = `ev_ret` = 1 with `commit_valid` = 1 records kind 0 and increments depth.
- Assert `rst` mid-stream with 5 entries stored:
  - Required: `rd_valid`, `count` and `cur_depth` drop to 0 immediately, without waiting for a clock edge.
  - After release, the first new event reads back correctly.
